serial_tx_seq: RTL and testbench

Sequencing controller for the team's 8-bit shift register (`sr_ctrl` codes below). It accepts parallel words over a valid/ready handshake and loads each word into the external register. It then steps the register LSB-first at a programmable bit rate and frames the bits as start / data / [parity] / stop on `ser_out`. It sits between any word producer and the shift register, and is the only block that drives the register's control inputs.

---
 rtl/serial_tx_seq.sv | 151 +++++++++++++++
 tb/tb_serial_tx_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_seq.sv
// serial_tx_seq: frames parallel words as start/data/[parity]/stop on ser_out by sequencing an external shift register.
// Optional even-parity bit: define SERIAL_TX_PARITY_EN.
module serial_tx_seq #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [1:0]       sr_ctrl,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_shift_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_LOAD  = 2'b01;
  localparam logic [1:0] SR_SHIFT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            div_last;

`ifdef SERIAL_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  // Only the LSB of the register is observed; the rest belongs to the register itself.
  logic unused_sr_q;
  assign unused_sr_q = ^sr_q[WIDTH-1:1];

  assign div_last    = (div_cnt_q == DIV_LAST);
  assign sr_shift_in = 1'b0;

  // NOTE: every output and next-state value gets a default before the case, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_last ? '0 : div_cnt_q + DW'(1);
    bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    in_ready  = 1'b0;
    sr_ctrl   = SR_HOLD;
    sr_data   = '0;
    ser_out   = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        div_cnt_d = '0;
        // rst gates the handshake so reset always presents the hold code to the register.
        in_ready  = ~rst;
        if (in_valid && in_ready) begin
          sr_ctrl = SR_LOAD;
          sr_data = in_data;
          state_d = S_START;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^in_data;
`endif
        end
      end

      S_START: begin
        ser_out = 1'b0;
        if (div_last) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end

      S_DATA: begin
        ser_out = sr_q[0];
        if (div_last) begin
          // The final bit is shifted out too, leaving the register cleared.
          sr_ctrl = SR_SHIFT;
          if (bit_cnt_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        ser_out = parity_q;
        if (div_last) state_d = S_STOP;
      end
`endif

      S_STOP: begin
        if (div_last) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        busy      = 1'b0;
        div_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx_seq.sv
// tb_serial_tx_seq: drives DIV=4 and DIV=1 instances of serial_tx_seq from shared stimulus, with a frame-level model
// checked every cycle plus hand-computed directed expectations. Honours SERIAL_TX_PARITY_EN like the RTL.
`timescale 1ns/1ps
module tb_serial_tx_seq;

`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
  localparam logic [10:0] PAT_A5 = 11'b10101001010;
  localparam logic [10:0] PAT_81 = 11'b10100000010;
`else
  localparam int P = 0;
  localparam logic [10:0] PAT_A5 = 11'b01101001010;
  localparam logic [10:0] PAT_81 = 11'b01100000010;
`endif
  localparam int F4 = (10 + P) * 4;
  localparam int F1 = (10 + P) * 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;

  logic       o_ready [2];
  logic [1:0] o_ctrl  [2];
  logic [7:0] o_data  [2];
  logic       o_shin  [2];
  logic       o_ser   [2];
  logic       o_busy  [2];
  logic       o_done  [2];
  logic [7:0] sr_reg  [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit         m_active [2];
  int         m_n      [2];
  logic [7:0] m_word   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_tx_seq #(.WIDTH(8), .DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(o_ready[0]),
    .sr_ctrl(o_ctrl[0]), .sr_data(o_data[0]), .sr_shift_in(o_shin[0]), .sr_q(sr_reg[0]),
    .ser_out(o_ser[0]), .busy(o_busy[0]), .done(o_done[0])
  );

  serial_tx_seq #(.WIDTH(8), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(o_ready[1]),
    .sr_ctrl(o_ctrl[1]), .sr_data(o_data[1]), .sr_shift_in(o_shin[1]), .sr_q(sr_reg[1]),
    .ser_out(o_ser[1]), .busy(o_busy[1]), .done(o_done[1])
  );

  // External shift registers; reset never touches them.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      case (o_ctrl[d])
        2'b01:   sr_reg[d] <= o_data[d];
        2'b10:   sr_reg[d] <= {o_shin[d], sr_reg[d][7:1]};
        default: sr_reg[d] <= sr_reg[d];
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: position k within a frame selects the serial bit as (k-1)/DIV.
  task automatic model_step(input int d);
    int dv, f, k, idx, ph;
    logic e_ready, e_ser, e_busy, e_done;
    logic [1:0] e_ctrl;
    dv = (d == 0) ? 4 : 1;
    f  = (10 + P) * dv;
    e_ready = 1'b0; e_ctrl = 2'b00; e_ser = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    if (m_active[d] && (cyc - m_n[d]) > f) m_active[d] = 1'b0;
    if (rst) begin
      m_active[d] = 1'b0;
    end else if (!m_active[d]) begin
      e_ready = 1'b1;
      if (in_valid) begin
        e_ctrl      = 2'b01;
        m_active[d] = 1'b1;
        m_n[d]      = cyc;
        m_word[d]   = in_data;
        check($sformatf("d%0d_load_data", d), o_data[d], in_data);
      end
    end else begin
      k   = cyc - m_n[d];
      idx = (k - 1) / dv;
      ph  = (k - 1) % dv;
      e_busy = 1'b1;
      if (idx == 0)                  e_ser = 1'b0;
      else if (idx <= 8)             e_ser = m_word[d][idx-1];
      else if (P == 1 && idx == 9)   e_ser = ^m_word[d];
      else                           e_ser = 1'b1;
      if (idx >= 1 && idx <= 8 && ph == dv - 1) e_ctrl = 2'b10;
      e_done = (k == f);
    end
    check($sformatf("d%0d_in_ready", d), o_ready[d], e_ready);
    check($sformatf("d%0d_sr_ctrl", d),  o_ctrl[d],  e_ctrl);
    check($sformatf("d%0d_ser_out", d),  o_ser[d],   e_ser);
    check($sformatf("d%0d_busy", d),     o_busy[d],  e_busy);
    check($sformatf("d%0d_done", d),     o_done[d],  e_done);
    check($sformatf("d%0d_shift_in", d), o_shin[d],  1'b0);
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Raises in_valid with w and returns the accept cycle of the DIV=4 instance.
  task automatic send(input logic [7:0] w, output int n);
    in_valid = 1'b1;
    in_data  = w;
    n = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (o_ready[0]) begin
        n = cyc;
        break;
      end
    end
    if (n < 0) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, n2;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", o_ready[0], 1'b0);
    check("rst_ser_out",  o_ser[0],   1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_div4", o_ready[0], 1'b1);
    check("post_rst_ready_div1", o_ready[1], 1'b1);

    // Quiet period with in_valid low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("quiet_sr_ctrl", o_ctrl[0], 2'b00);
      check("quiet_ser_out", o_ser[0],  1'b1);
      check("quiet_busy",    o_busy[0], 1'b0);
    end
    @(posedge clk); #1;

    // 0xA5, DIV=4: literal frame pattern, shift cycles and done position.
    send(8'hA5, n);
    for (int k = 1; k <= F4; k++) begin
      @(negedge clk);
      check($sformatf("a5_ser_k%0d", k), o_ser[0], PAT_A5[(k-1)/4]);
      check($sformatf("a5_ctrl_k%0d", k), o_ctrl[0],
            (k >= 8 && k <= 36 && k % 4 == 0) ? 2'b10 : 2'b00);
      check($sformatf("a5_done_k%0d", k), o_done[0], k == F4);
    end
    @(negedge clk);
    check("a5_idle_ready", o_ready[0], 1'b1);
    check("a5_reg_cleared", sr_reg[0], 8'h00);
    idle_cycles(3);

    // 0x07: bit 7 is 0; cycles 37..40 carry parity 1 or stop 1.
    send(8'h07, n);
    for (int k = 1; k <= F4; k++) begin
      @(negedge clk);
      if (k >= 33 && k <= 36) check("x07_bit7", o_ser[0], 1'b0);
      if (k >= 37 && k <= 40) check("x07_k37_40", o_ser[0], 1'b1);
      if (k >= 41)            check("x07_stop", o_ser[0], 1'b1);
      check("x07_done", o_done[0], k == 10 * 4 + 4 * P);
    end
    idle_cycles(3);

    // 0x81 on the DIV=1 instance: one bit per cycle, shift every DATA cycle.
    send(8'h81, n);
    for (int k = 1; k <= F1; k++) begin
      @(negedge clk);
      check($sformatf("x81_ser_k%0d", k), o_ser[1], PAT_81[k-1]);
      check($sformatf("x81_ctrl_k%0d", k), o_ctrl[1], (k >= 2 && k <= 9) ? 2'b10 : 2'b00);
      check($sformatf("x81_done_k%0d", k), o_done[1], k == F1);
    end
    idle_cycles(F4);

    // Back-to-back with in_valid held.
    in_valid = 1'b1; in_data = 8'h00;
    n1 = -1;
    for (int t = 0; t < 100 && n1 < 0; t++) begin
      @(negedge clk);
      if (o_ready[0]) n1 = cyc;
    end
    @(posedge clk); #1;
    in_data = 8'hFF;
    n2 = -1;
    for (int t = 0; t < 100 && n2 < 0; t++) begin
      @(negedge clk);
      if (o_ready[0]) n2 = cyc;
    end
    check("b2b_spacing", n2 - n1, F4 + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle_cycles(F4 + 2);
    check("b2b_reg_cleared", sr_reg[0], 8'h00);

    // Reset mid-DATA after two shifts of 0x3C.
    send(8'h3C, n);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ctrl",  o_ctrl[0],  2'b00);
    check("rst_mid_ser",   o_ser[0],   1'b1);
    check("rst_mid_busy",  o_busy[0],  1'b0);
    check("rst_mid_ready", o_ready[0], 1'b0);
    check("rst_mid_done",  o_done[0],  1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_ready", o_ready[0], 1'b1);
    check("rst_reg_kept",  sr_reg[0],  8'h0F);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("rst_no_done", o_done[0], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
